seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for NUM_DIGITS seven-segment digits sharing one segment bus.
//  Rotates through the digits at a programmable rate and decodes hex glyphs or test patterns.
//  Supports per-digit blink, decimal points, anti-ghost blanking and runtime CA/CC polarity.
//  Sits between the display-value logic and the chip's segment/select pads.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned, 2..8
//  PRESCALE      1000  clk cycles per digit slot, >= 2
//  BLANK_CYCLES  2     leading cycles of each slot with all selects inactive, 0..PRESCALE-1
//  BLINK_DIV     64    scan frames per blink half-period, >= 1
// PORTS
//  clk             in   1               system clock
//  rst             in   1               synchronous reset, active-high
//  en              in   1               scan enable
//  digits          in   4*NUM_DIGITS    hex value per digit; digit i = digits[4i+3:4i]
//  dp_in           in   NUM_DIGITS      decimal point per digit, 1 = lit
//  blink_mask      in   NUM_DIGITS      1 = digit blinks
//  pattern         in   2               0 = normal, 1 = all on, 2 = a/g/d bars, 3 = g only
//  common_cathode  in   1               1 = seg/dp active-high, an active-low; 0 = inverse
//  seg             out  7               {g,f,e,d,c,b,a}
//  dp              out  1               decimal-point segment
//  an              out  NUM_DIGITS      digit selects, one-hot when active
//  frame_tick      out  1               1-cycle pulse at start of each frame
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
//  Reset: pcnt=0, idx=0, frame counter=0, blink_phase=0, snapshot regs=0.
//   seg/dp/an are driven to their inactive levels for the current common_cathode. frame_tick=0.
//  Prescaler: with en=1, pcnt counts 0..PRESCALE-1, then wraps to 0.
//   On wrap, idx increments; NUM_DIGITS-1 -> 0.
//  Frame wrap: at the edge where idx goes NUM_DIGITS-1 -> 0:
//   - digits/dp_in/blink_mask are copied into snapshot regs (no tearing mid-frame).
//   - the frame counter increments.
//   - frame_tick is 1 for the following cycle only.
//  Blink: the frame counter counts 0..BLINK_DIV-1. On its wrap, blink_phase toggles.
//  Outputs: registered, 1-cycle latency from (idx, pcnt, snapshot, pattern, common_cathode).
//   pattern and common_cathode are used live, not snapshotted.
//  Glyphs (active-high, {g..a}):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  Pattern overrides the glyph: 1 -> 7F; 2 -> 49; 3 -> 40. dp comes from the snapshot in all patterns.
//  Blanking: if the snapshot blink bit of idx is 1 and blink_phase=1, seg=0 and dp=0 (active-high view).
//   The select stays active while blanked.
//  Anti-ghost: while pcnt < BLANK_CYCLES, all an are inactive. Otherwise only an[idx] is active.
//  Polarity: common_cathode=0 inverts seg and dp and makes an one-hot high.
//   common_cathode=1 keeps seg/dp active-high and makes an one-hot low.
//   A polarity change takes effect on the next cycle.
//  en=0: pcnt, idx, frame and blink state hold. Next cycle seg/dp/an go inactive and frame_tick=0.
//   Re-asserting en resumes from the held state.
//  Reset mid-slot: everything returns to reset values on the next edge. The first frame shows the zero snapshot.
//  Simultaneous pcnt wrap and frame wrap: snapshot, frame count and blink toggle all update on the same edge.
// TESTING (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, BLINK_DIV=2, CC=1)
//  1. Reset, en=1, digits=16'h3210 -> after the first frame_tick, slots show seg 3F,06,5B,4F.
//     an=1110,1101,1011,0111; first cycle of each slot an=1111.
//  2. Change digits to 16'hFEDC mid-frame -> current frame unchanged; next frame shows 39,5E,79,71.
//     frame_tick spaced exactly 16 cycles apart.
//  3. blink_mask=4'b0010 -> digit 1 seg=00 for 2 frames, then glyph for 2 frames, repeating.
//     Other digits are unaffected.
//  4. pattern=1,2,3 -> seg 7F, 49, 40 on every digit.
//     CC=0 -> seg inverted (00, 36, 3F) and an one-hot high.
//  5. en=0 for 10 cycles mid-slot -> outputs inactive; idx/pcnt frozen.
//     Slot resumes with its remaining cycles after en=1.
//  6. rst pulsed mid-frame -> next cycle outputs inactive and idx=0.
//     Snapshot is 0, so the first frame shows 3F on all digits.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: rotates through the digits, decodes hex or test
// patterns, and applies blink, decimal points, anti-ghost blanking and runtime CA/CC polarity.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_DIV    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [1:0]              pattern,
  input  logic                    common_cathode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_DIV - 1);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blink;

  logic                  slot_wrap, frame_wrap, blink_wrap;
  logic [3:0]            cur_digit;
  logic [6:0]            glyph, seg_hi, seg_nxt, seg_off;
  logic                  dp_hi, dp_nxt, dp_off;
  logic [NUM_DIGITS-1:0] an_hi, an_nxt, an_off;

  assign slot_wrap  = (pcnt == P_LAST);
  assign frame_wrap = slot_wrap && (idx == I_LAST);
  assign blink_wrap = frame_wrap && (frame_cnt == F_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
    end else if (en) begin
      pcnt <= slot_wrap ? '0 : pcnt + 1'b1;
      if (slot_wrap)
        idx <= frame_wrap ? '0 : idx + 1'b1;
      // Snapshot at the frame boundary so a value change never tears a frame.
      if (frame_wrap) begin
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_blink  <= blink_mask;
        frame_cnt   <= blink_wrap ? '0 : frame_cnt + 1'b1;
        if (blink_wrap)
          blink_phase <= ~blink_phase;
      end
    end
  end

  always_comb begin
    cur_digit = snap_digits[{idx, 2'b00} +: 4];
    glyph     = 7'h00;
    case (cur_digit)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase

    case (pattern)
      2'd1:    seg_hi = 7'h7F;
      2'd2:    seg_hi = 7'h49;
      2'd3:    seg_hi = 7'h40;
      default: seg_hi = glyph;
    endcase
    dp_hi = snap_dp[idx];
    if (snap_blink[idx] && blink_phase) begin
      seg_hi = 7'h00;
      dp_hi  = 1'b0;
    end

    // Selects stay off for the first slot cycles so the previous digit's segments can settle.
    an_hi = '0;
    if (pcnt >= P_BLANK)
      an_hi[idx] = 1'b1;

    seg_off = common_cathode ? 7'h00 : 7'h7F;
    dp_off  = ~common_cathode;
    an_off  = common_cathode ? '1 : '0;
    seg_nxt = common_cathode ? seg_hi : ~seg_hi;
    dp_nxt  = common_cathode ? dp_hi : ~dp_hi;
    an_nxt  = common_cathode ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      seg        <= seg_off;
      dp         <= dp_off;
      an         <= an_off;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      an         <= an_nxt;
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver using a time-based reference model:
// slot, digit, frame and blink phase are all derived from the count of enabled cycles.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int BL = 1;
  localparam int BD = 2;
  localparam int PN = P * N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   blink_mask = '0;
  logic [1:0]     pattern = 2'd0;
  logic           common_cathode = 1'b1;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_tick;

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(BL), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
    .blink_mask(blink_mask), .pattern(pattern), .common_cathode(common_cathode),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model state: enabled cycles since reset plus the latched frame inputs.
  int           t = 0;
  logic [4*N-1:0] m_dig = '0;
  logic [N-1:0]   m_dp = '0;
  logic [N-1:0]   m_blink = '0;

  logic [6:0]   e_seg;
  logic         e_dp;
  logic [N-1:0] e_an;
  logic         e_ft;

  // Computes what the DUT should show after the coming edge, advances the model, and steps.
  task automatic cycle();
    int p, i, f;
    logic [6:0]   s;
    logic         d;
    logic [N-1:0] a;
    if (rst || !en) begin
      e_seg = common_cathode ? 7'h00 : 7'h7F;
      e_dp  = ~common_cathode;
      e_an  = common_cathode ? '1 : '0;
      e_ft  = 1'b0;
    end else begin
      p = t % P;
      i = (t / P) % N;
      f = t / PN;
      case (pattern)
        2'd1:    s = 7'h7F;
        2'd2:    s = 7'h49;
        2'd3:    s = 7'h40;
        default: s = glyph_tab[m_dig[4*i +: 4]];
      endcase
      d = m_dp[i];
      if (m_blink[i] && ((f / BD) % 2 == 1)) begin
        s = 7'h00;
        d = 1'b0;
      end
      a = '0;
      if (p >= BL) a[i] = 1'b1;
      e_seg = common_cathode ? s : ~s;
      e_dp  = common_cathode ? d : ~d;
      e_an  = common_cathode ? ~a : a;
      e_ft  = (t % PN) == PN - 1;
    end
    if (rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_blink = '0;
    end else if (en) begin
      if (t % PN == PN - 1) begin
        m_dig = digits; m_dp = dp_in; m_blink = blink_mask;
      end
      t++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; digits = 16'h3210;
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++;
      if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
        bad++;
        $display("FAIL reset cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                 cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int last_tick = -1;
    int ticks = 0;
    for (int k = 0; k < 56; k++) begin
      if (k == 22) digits = 16'hFEDC;
      cycle();
      total++;
      if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
        bad++;
        $display("FAIL scan cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                 cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          total++;
          if (cyc - last_tick != PN) begin
            bad++;
            $display("FAIL tick_spacing got=%0d want=%0d", cyc - last_tick, PN);
          end
        end
        last_tick = cyc;
        ticks++;
      end
    end
    total++;
    if (ticks < 3) begin
      bad++;
      $display("FAIL tick_count got=%0d want>=3", ticks);
    end
  endtask

  task automatic test_blink();
    blink_mask = 4'b0010;
    dp_in = 4'b1010;
    for (int k = 0; k < 5 * PN; k++) begin
      cycle();
      total++;
      if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
        bad++;
        $display("FAIL blink cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                 cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_pattern();
    for (int c = 1; c >= 0; c--) begin
      for (int p = 1; p <= 3; p++) begin
        common_cathode = c[0];
        pattern = p[1:0];
        for (int k = 0; k < 12; k++) begin
          cycle();
          total++;
          if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
            bad++;
            $display("FAIL pattern%0d cc=%0d cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                     p, c, cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
          end
        end
      end
    end
    pattern = 2'd0;
    common_cathode = 1'b1;
  endtask

  task automatic test_enable();
    for (int k = 0; k < 38; k++) begin
      en = !(k >= 6 && k < 16);
      cycle();
      total++;
      if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
        bad++;
        $display("FAIL enable cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                 cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 30; k++) begin
      rst = (k == 7);
      cycle();
      total++;
      if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                 cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 29) == 0) pattern = 2'($urandom);
      if ($urandom_range(0, 29) == 0) common_cathode = ~common_cathode;
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      total++;
      if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_tick !== e_ft) begin
        bad++;
        $display("FAIL random cyc=%0d seg=%h/%h dp=%b/%b an=%b/%b ft=%b/%b",
                 cyc, seg, e_seg, dp, e_dp, an, e_an, frame_tick, e_ft);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_pattern();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
